// File: rtl/delay_probe_if.sv
// Probe/echo handshake bundle between a delay_probe and whatever drives and observes it.
// The master side issues start and returns the echo; the slave side is the probe engine.
interface delay_probe_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             echo_in;
  logic             probe_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] latency;

  modport master (
    output start,
    output echo_in,
    input  probe_out,
    input  busy,
    input  done,
    input  timeout,
    input  latency
  );

  modport slave (
    input  start,
    input  echo_in,
    output probe_out,
    output busy,
    output done,
    output timeout,
    output latency
  );
endinterface

// File: rtl/delay_probe.sv
// Round-trip latency probe: fires a pulse on probe_out and counts clock edges until the
// echo's rising edge comes back on echo_in, or reports a timeout.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// SEND   | probe_out high, counting, watching for echo
// WAIT   | probe_out low, counting, watching for echo
module delay_probe #(
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 200,
  parameter int PULSE_LEN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  delay_probe_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_PULSE   = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_latency;
  logic             r_probe;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic             r_echo_q;

  logic [CNT_W-1:0] w_k;
  logic             w_rise;
  logic             w_expire;

  // w_k is the edge index k of the edge currently being taken (r_cnt holds k-1)
  assign w_k      = r_cnt + C_ONE;
  assign w_rise   = bus.echo_in & ~r_echo_q;
  assign w_expire = (w_k == C_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pcnt    <= '0;
      r_latency <= '0;
      r_probe   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_echo_q  <= 1'b0;
    end else begin
      r_echo_q  <= bus.echo_in;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_SEND;
            r_busy  <= 1'b1;
            r_probe <= 1'b1;
            r_cnt   <= '0;
            r_pcnt  <= C_ONE;
          end
        end
        S_SEND, S_WAIT: begin
          r_cnt <= w_k;
          // echo beats timeout on the same edge, and may cut the probe pulse short
          if (w_rise) begin
            r_latency <= w_k;
            r_done    <= 1'b1;
            r_probe   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_probe   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_state == S_SEND) begin
            if (r_pcnt == C_PULSE) begin
              r_probe <= 1'b0;
              r_state <= S_WAIT;
            end else begin
              r_pcnt <= r_pcnt + C_ONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_probe <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.probe_out = r_probe;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.latency   = r_latency;

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: expected results are queued at start time from a rising-edge
// search over the echo waveform; a negedge monitor pops and compares each result.
module tb_delay_probe;
  localparam int CNT_W = 8;
  localparam int TO    = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_probe_if #(.CNT_W(CNT_W)) bus ();
  delay_probe_if #(.CNT_W(CNT_W)) bus6 ();

  delay_probe #(.CNT_W(CNT_W), .TIMEOUT(TO), .PULSE_LEN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  delay_probe #(.CNT_W(CNT_W), .TIMEOUT(TO), .PULSE_LEN(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic       mode_line = 1'b0;
  int         line_len = 0;
  logic       echo_drv = 1'b0;
  logic [7:0] sh = '0;
  logic [7:0] sh6 = '0;

  // environment: free-running delay lines fed by each probe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sh  <= {sh[6:0], bus.probe_out};
    sh6 <= {sh6[6:0], bus6.probe_out};
  end

  assign bus.echo_in  = mode_line ? ((line_len == 0) ? bus.probe_out : sh[line_len-1]) : echo_drv;
  assign bus6.echo_in = sh6[2];

  typedef struct {
    bit         is_to;
    logic [7:0] lat;
    int         cyc;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] model_lat = '0;
  bit ev [0:TO];

  int nprobe = 0;
  int pw_run = 0;
  int pw_last = 0;
  logic probe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.probe_out && !probe_prev) nprobe++;
    if (bus.probe_out) pw_run++;
    else if (pw_run != 0) begin
      pw_last = pw_run;
      pw_run  = 0;
    end
    probe_prev = bus.probe_out;
  end

  always @(negedge clk) begin
    if (rst_n && (bus.done || bus.timeout)) begin
      check("pending_expect", (sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("kind_timeout", bus.timeout, e.is_to);
        check("done_xor_timeout", bus.done & bus.timeout, 0);
        check("latency", bus.latency, e.lat);
        check("result_cycle", cyc, e.cyc);
        check("busy_with_result", bus.busy, 0);
      end
    end
  end

  task automatic push_exp(input bit is_to, input int lat, input int c);
    exp_t e;
    e.is_to = is_to;
    e.lat   = 8'(lat);
    e.cyc   = c;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < TO + 50 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic run_line(input int d);
    int c0;
    @(negedge clk);
    mode_line = 1'b1;
    line_len  = d;
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    c0 = cyc + 1;
    push_exp(0, d + 1, c0 + d + 1);
    model_lat = 8'(d + 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
  endtask

  task automatic run_script();
    int k_hit = 0;
    int c0;
    int last;
    for (int j = 1; j <= TO; j++)
      if (k_hit == 0 && ev[j] && !ev[j-1]) k_hit = j;
    @(negedge clk);
    mode_line = 1'b0;
    echo_drv  = ev[0];
    bus.start = 1'b1;
    c0 = cyc + 1;
    if (k_hit > 0) begin
      push_exp(0, k_hit, c0 + k_hit);
      model_lat = 8'(k_hit);
    end else begin
      push_exp(1, model_lat, c0 + TO);
    end
    last = (k_hit > 0) ? k_hit : TO;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      echo_drv  = ev[j];
    end
    wait_drain();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int last;
    int n0;
    int pw6;
    bit hit;
    bus.start  = 1'b0;
    bus6.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_probe", bus.probe_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_latency", bus.latency, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_line(0);
    check("loopback_pulse_width", pw_last, 1);
    run_line(3);

    for (int j = 0; j <= TO; j++) ev[j] = 1'b0;
    run_script();

    for (int j = 0; j <= TO; j++) ev[j] = (j < 5) || (j >= 9);
    run_script();

    for (int j = 0; j <= TO; j++) ev[j] = (j == TO);
    run_script();

    // back-to-back: start held high, one idle cycle between measurements
    @(negedge clk);
    mode_line = 1'b1;
    line_len  = 3;
    repeat (9) @(negedge clk);
    n0 = nprobe;
    bus.start = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 4; i++) push_exp(0, 4, c0 + 4 + 5 * i);
    model_lat = 8'd4;
    last = c0 + 4 + 5 * 3;
    for (int i = 0; i < 100 && cyc < last; i++) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    check("b2b_probe_count", nprobe - n0, 4);

    // reset in mid-measurement
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_probe", bus.probe_out, 0);
    model_lat = 8'd0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_latency", bus.latency, 0);
    check("post_rst_done", bus.done, 0);
    run_line(3);

    // long probe pulse cut short by the echo
    @(negedge clk);
    bus6.start = 1'b1;
    c0  = cyc + 1;
    pw6 = 0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      bus6.start = 1'b0;
      if (bus6.probe_out) pw6++;
      if (bus6.done || bus6.timeout) hit = 1'b1;
    end
    check("p6_result_seen", hit, 1);
    check("p6_done", bus6.done, 1);
    check("p6_latency", bus6.latency, 4);
    check("p6_cycle", cyc, c0 + 4);
    check("p6_probe_width", pw6, 4);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_line($urandom_range(0, 7));
      end else begin
        ev[0] = 1'($urandom_range(0, 1));
        for (int j = 1; j <= TO; j++)
          ev[j] = ($urandom_range(0, 63) == 0) ? ~ev[j-1] : ev[j-1];
        run_script();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
